// File: rtl/core_pkg.sv
// Shared definitions for the multicycle core: fetch FSM states and branch func3 encodings.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch resolution: func3 plus ALU flags to taken, with the
// two reserved func3 encodings reported as illegal and never taken.
module branch_cond
  import core_pkg::*;
(
  input  logic [2:0] i_func3,
  input  logic       i_zero,
  input  logic       i_lt,
  input  logic       i_ltu,
  output logic       o_taken,
  output logic       o_illegal
);

  // Decode the branch type against the ALU flags.
  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    case (i_func3)
      BR_EQ:          o_taken   = i_zero;
      BR_NE:          o_taken   = ~i_zero;
      BR_LT:          o_taken   = i_lt;
      BR_GE:          o_taken   = ~i_lt;
      BR_LTU:         o_taken   = i_ltu;
      BR_GEU:         o_taken   = ~i_ltu;
      3'b010, 3'b011: o_illegal = 1'b1;
      default:        o_taken   = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch unit: PC update with jump/branch/write
// priority and misalignment trapping, plus an IDLE/REQ/WAIT fetch handshake with timeout.
module fetch_pc_unit
  import core_pkg::*;
#(
  parameter int              XLEN       = 64,
  parameter int              ILEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}},
  parameter int              ALIGN_BITS = 2,
  parameter int              TIMEOUT    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_start,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] ir_out,
  output logic            ir_valid,
  output logic            busy,
  output logic            fetch_err,
  input  logic            pc_write,
  input  logic [XLEN-1:0] pc_next_in,
  input  logic            br_en,
  input  logic [2:0]      br_func3,
  input  logic            alu_zero,
  input  logic            alu_lt,
  input  logic            alu_ltu,
  input  logic            jump_en,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc_out,
  output logic            misalign_trap,
  output logic [XLEN-1:0] bad_addr,
  output logic            br_illegal
);

  localparam int              CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CNT_MAX    = {CW{1'b1}};
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_bad_addr;
  logic [ILEN-1:0] r_ir;
  logic            r_ir_valid;
  logic            r_req;
  logic            r_busy;
  logic            r_err;
  logic            r_trap;
  logic            r_illegal;
  logic            w_cond_taken;
  logic            w_cond_illegal;
  logic            w_idle;
  logic            w_sel_target;
  logic            w_misalign;
  logic            w_capture;
  logic            w_timeout;
  logic            w_trap;

  branch_cond u_branch_cond (
    .i_func3   (br_func3),
    .i_zero    (alu_zero),
    .i_lt      (alu_lt),
    .i_ltu     (alu_ltu),
    .o_taken   (w_cond_taken),
    .o_illegal (w_cond_illegal)
  );

  assign w_idle       = (r_state == IDLE);
  assign w_sel_target = jump_en | (br_en & w_cond_taken);
  assign w_misalign   = w_sel_target & (|(target & ALIGN_MASK));

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Fetch FSM next state; a response on the last allowed WAIT cycle still wins over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (fetch_start) w_state_nxt = REQ;
        else             w_state_nxt = IDLE;
      end
      REQ:  w_state_nxt = WAIT;
      WAIT: begin
        if (imem_rvalid)              w_state_nxt = IDLE;
        else if (r_cnt == CNT_LAST)   w_state_nxt = IDLE;
        else                          w_state_nxt = WAIT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Fetch FSM output decode feeding the registered handshake outputs.
  always_comb begin
    w_capture = 1'b0;
    w_timeout = 1'b0;
    if (r_state == WAIT) begin
      w_capture = imem_rvalid;
      w_timeout = ~imem_rvalid & (r_cnt == CNT_LAST);
    end else begin
      w_capture = 1'b0;
      w_timeout = 1'b0;
    end
  end

  // PC source selection; a misaligned target blocks every source for this cycle.
  always_comb begin
    w_pc_nxt = r_pc;
    w_trap   = 1'b0;
    if (w_idle) begin
      if (w_sel_target) begin
        if (w_misalign) begin
          w_trap   = 1'b1;
          w_pc_nxt = r_pc;
        end else begin
          w_pc_nxt = target;
        end
      end else if (pc_write) begin
        w_pc_nxt = pc_next_in;
      end else begin
        w_pc_nxt = r_pc;
      end
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  // Saturating WAIT-cycle counter, cleared on each request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                           r_cnt <= {CW{1'b0}};
    else if (r_state == REQ)                              r_cnt <= {CW{1'b0}};
    else if ((r_state == WAIT) && (r_cnt != CNT_MAX))     r_cnt <= r_cnt + CW'(1);
    else                                                  r_cnt <= r_cnt;
  end

  // Registered PC, IR and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_bad_addr <= {XLEN{1'b0}};
      r_ir       <= {ILEN{1'b0}};
      r_ir_valid <= 1'b0;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_trap     <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_req     <= (w_state_nxt == REQ);
      r_busy    <= (w_state_nxt != IDLE);
      r_err     <= w_timeout;
      r_trap    <= w_trap;
      r_illegal <= br_en & w_cond_illegal;
      if (w_trap) r_bad_addr <= target;
      else        r_bad_addr <= r_bad_addr;
      if (w_capture) r_ir <= imem_rdata;
      else           r_ir <= r_ir;
      if (w_idle && fetch_start) r_ir_valid <= 1'b0;
      else if (w_capture)        r_ir_valid <= 1'b1;
      else                       r_ir_valid <= r_ir_valid;
    end
  end

  assign imem_req      = r_req;
  assign imem_addr     = r_pc;
  assign pc_out        = r_pc;
  assign ir_out        = r_ir;
  assign ir_valid      = r_ir_valid;
  assign busy          = r_busy;
  assign fetch_err     = r_err;
  assign misalign_trap = r_trap;
  assign bad_addr      = r_bad_addr;
  assign br_illegal    = r_illegal;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed plus randomized bench for fetch_pc_unit against a behavioural model of
// the PC priority rules and the fetch handshake timing.
module tb_fetch_pc_unit;

  localparam int              XLEN       = 64;
  localparam int              ILEN       = 32;
  localparam int              TIMEOUT    = 4;
  localparam int              ALIGN_BITS = 2;
  localparam logic [XLEN-1:0] RESET_PC   = 64'h0;

  logic            clk, reset, fetch_start, imem_req, imem_rvalid;
  logic [XLEN-1:0] imem_addr, pc_next_in, target, pc_out, bad_addr;
  logic [ILEN-1:0] imem_rdata, ir_out;
  logic            ir_valid, busy, fetch_err, pc_write, br_en, alu_zero, alu_lt, alu_ltu;
  logic            jump_en, misalign_trap, br_illegal;
  logic [2:0]      br_func3;

  fetch_pc_unit #(
    .XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RESET_PC), .ALIGN_BITS(ALIGN_BITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir_out(ir_out), .ir_valid(ir_valid), .busy(busy), .fetch_err(fetch_err),
    .pc_write(pc_write), .pc_next_in(pc_next_in), .br_en(br_en), .br_func3(br_func3),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .jump_en(jump_en),
    .target(target), .pc_out(pc_out), .misalign_trap(misalign_trap),
    .bad_addr(bad_addr), .br_illegal(br_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [XLEN-1:0] m_pc, m_bad;
  logic [ILEN-1:0] m_ir;
  logic            m_irv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    fetch_start = 1'b0; pc_write = 1'b0; br_en = 1'b0; jump_en = 1'b0;
    br_func3 = 3'd0; alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
    pc_next_in = 64'h0; target = 64'h0; imem_rvalid = 1'b0;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_bad = 64'h0; m_ir = 32'h0; m_irv = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"},    pc_out, RESET_PC);
    chk({tag, "_ir"},    ir_out, 64'h0);
    chk({tag, "_stat"},  {ir_valid, busy, imem_req, fetch_err, misalign_trap, br_illegal}, 64'h0);
    chk({tag, "_bad"},   bad_addr, 64'h0);
  endtask

  // Branch truth table as written in the ISA: equality and the two compare flavours.
  function automatic bit model_taken(input logic [2:0] f, input logic z, input logic lt, input logic ltu);
    case (f)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return lt;
      3'd5:    return !lt;
      3'd6:    return ltu;
      3'd7:    return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  // One PC-update request in IDLE, checked on the next cycle and for single-cycle pulses after.
  task automatic pc_step(input string tag, input logic jmp, input logic br, input logic [2:0] f3,
                         input logic z, input logic lt, input logic ltu,
                         input logic [63:0] tgt, input logic pcw, input logic [63:0] nxt);
    logic use_t, exp_trap, exp_ill;
    jump_en = jmp; br_en = br; br_func3 = f3; alu_zero = z; alu_lt = lt; alu_ltu = ltu;
    target = tgt; pc_write = pcw; pc_next_in = nxt;
    exp_ill  = br && (f3 == 3'd2 || f3 == 3'd3);
    use_t    = jmp || (br && model_taken(f3, z, lt, ltu));
    exp_trap = use_t && ((tgt % (64'd1 << ALIGN_BITS)) != 64'd0);
    if (use_t) begin
      if (exp_trap) m_bad = tgt;
      else          m_pc  = tgt;
    end else if (pcw) begin
      m_pc = nxt;
    end
    tick();
    clear_ctl();
    chk({tag, "_pc"},   pc_out, m_pc);
    chk({tag, "_trap"}, misalign_trap, exp_trap);
    chk({tag, "_bad"},  bad_addr, m_bad);
    chk({tag, "_ill"},  br_illegal, exp_ill);
    tick();
    chk({tag, "_pulse"}, {misalign_trap, br_illegal}, 64'h0);
  endtask

  // A fetch whose response arrives on WAIT cycle d (d >= TIMEOUT means never), optionally
  // combined with a pc_write in the start cycle and noise update requests while busy.
  task automatic run_fetch(input string tag, input int d, input logic [31:0] data,
                           input logic pcw, input logic [63:0] nxt, input logic noise);
    bit done;
    fetch_start = 1'b1; pc_write = pcw; pc_next_in = nxt;
    if (pcw) m_pc = nxt;
    tick();
    clear_ctl();
    m_irv = 1'b0;
    chk({tag, "_req"},  {imem_req, busy, ir_valid}, 64'h6);
    chk({tag, "_addr"}, imem_addr, m_pc);
    if (noise) begin
      pc_write = 1'b1; pc_next_in = {$urandom, $urandom};
      jump_en = 1'($urandom); target = {$urandom, $urandom} & ~64'h3;
      fetch_start = 1'b1;
    end
    tick();
    clear_ctl();
    chk({tag, "_req_pulse"}, imem_req, 1'b0);
    chk({tag, "_pc_hold"},   pc_out, m_pc);
    done = 1'b0;
    for (int k = 0; k < TIMEOUT && !done; k++) begin
      imem_rvalid = (k == d);
      imem_rdata  = (k == d) ? data : $urandom;
      if (noise) begin
        pc_write = 1'b1; pc_next_in = {$urandom, $urandom};
        br_en = 1'b1; br_func3 = 3'd1; alu_zero = 1'b0; target = {$urandom, $urandom} & ~64'h3;
      end
      tick();
      clear_ctl();
      chk({tag, "_pc_busy"}, pc_out, m_pc);
      if (k == d) begin
        m_ir = data; m_irv = 1'b1; done = 1'b1;
        chk({tag, "_ir"},  ir_out, m_ir);
        chk({tag, "_irv"}, {ir_valid, busy, fetch_err}, 64'h4);
      end else if (k == TIMEOUT - 1) begin
        done = 1'b1;
        chk({tag, "_tmo"},    {fetch_err, busy, ir_valid}, 64'h4);
        chk({tag, "_tmo_ir"}, ir_out, m_ir);
      end else begin
        chk({tag, "_wait"}, {fetch_err, busy}, 64'h1);
      end
    end
    // Stray response in IDLE must be ignored and the error must not repeat.
    imem_rvalid = 1'b1; imem_rdata = $urandom;
    tick();
    clear_ctl();
    chk({tag, "_late_ir"},  ir_out, m_ir);
    chk({tag, "_late_st"},  {ir_valid, busy, fetch_err, imem_req}, {63'h0, m_irv} << 3);
  endtask

  initial begin
    clear_ctl();
    imem_rdata = 32'h0;
    reset = 1'b0;
    model_reset();
    #2;
    chk_reset_outputs("reset");
    #10 reset = 1'b1;
    tick();

    run_fetch("fetch0", 0, 32'h00500093, 1'b0, 64'h0, 1'b1);
    pc_step("pcw4",    1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 64'h100, 1'b1, 64'h4);
    pc_step("bne",     1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 64'h100, 1'b0, 64'h0);
    pc_step("beq_nt",  1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 64'h100, 1'b1, 64'h8);
    pc_step("bltu",    1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 64'h100, 1'b0, 64'h0);
    pc_step("illegal", 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 64'h200, 1'b0, 64'h0);
    pc_step("jmp_mis", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 64'h102, 1'b1, 64'h40);
    run_fetch("timeout", TIMEOUT, 32'h0, 1'b0, 64'h0, 1'b0);
    run_fetch("start_pcw", 1, 32'hdeadbeef, 1'b1, 64'h200, 1'b0);

    // Reset during REQ drops the request at once.
    fetch_start = 1'b1;
    tick();
    clear_ctl();
    chk("rstreq_pre", imem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rstreq_req", imem_req, 1'b0);
    #3 reset = 1'b1;
    model_reset();
    tick();

    run_fetch("warm", 0, 32'h13579bdf, 1'b1, 64'h80, 1'b0);
    pc_step("misal2", 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 64'h305, 1'b0, 64'h0);
    // Reset during WAIT: every output returns to its reset value without an error pulse.
    fetch_start = 1'b1;
    tick();
    clear_ctl();
    tick();
    chk("rstwait_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_reset_outputs("rstwait");
    #3 reset = 1'b1;
    model_reset();
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hffffffff;
    tick();
    tick();
    clear_ctl();
    chk("post_rst_ign", {ir_valid, busy, fetch_err}, 64'h0);
    chk("post_rst_ir",  ir_out, 64'h0);
    run_fetch("post_rst", 0, 32'h00a00113, 1'b0, 64'h0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      if (i % 8 == 7) begin
        run_fetch("rnd_fetch", int'($urandom_range(0, TIMEOUT)), $urandom,
                  1'($urandom), {$urandom, $urandom} & ~64'h3, 1'($urandom));
      end else begin
        pc_step("rnd", ($urandom % 4) == 0, 1'($urandom), 3'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom),
                {$urandom, $urandom} & ((($urandom % 3) == 0) ? 64'hffffffffffffffff : ~64'h3),
                1'($urandom), {$urandom, $urandom});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
